// File: rtl/pid_frame_scheduler.sv
// Once per control period, snapshots fdb/ref and issues each enabled channel to the shared PID core in ascending order.
// Optional macro PID_SCHED_TIMEOUT_EN: a channel whose result never arrives is skipped after TIMEOUT WAIT cycles.
module pid_frame_scheduler #(
    parameter int  DATA_WIDTH = 16,
    parameter int  NUM_CHN    = 4,
    parameter int  PERIOD_W   = 16,
    parameter int  TIMEOUT    = 64,
    localparam int CHN_WIDTH  = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [PERIOD_W-1:0]           period,
    input  logic [NUM_CHN-1:0]            chn_mask,
    input  logic [NUM_CHN*DATA_WIDTH-1:0] fdb_i,
    input  logic [NUM_CHN*DATA_WIDTH-1:0] ref_i,
    output logic                          data_valid_o,
    output logic [CHN_WIDTH-1:0]          data_chn_o,
    output logic [DATA_WIDTH-1:0]         data_fdb_o,
    output logic [DATA_WIDTH-1:0]         data_ref_o,
    input  logic                          tready_i,
    input  logic                          u_valid_i,
    input  logic [CHN_WIDTH-1:0]          u_chn_i,
    input  logic [DATA_WIDTH-1:0]         u_data_i,
    output logic [NUM_CHN*DATA_WIDTH-1:0] u_bank_o,
    output logic [NUM_CHN-1:0]            u_update_o,
    output logic                          frame_done_o,
    output logic                          busy_o,
    output logic                          overrun_o,
    output logic                          timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                        r_state, w_state_nxt;
    logic [PERIOD_W-1:0]           r_cnt, r_per, w_per_now, w_per_eff;
    logic                          w_tick;
    logic [NUM_CHN-1:0]            r_mask;
    logic [DATA_WIDTH-1:0]         r_snap_fdb [NUM_CHN];
    logic [DATA_WIDTH-1:0]         r_snap_ref [NUM_CHN];
    logic [CHN_WIDTH-1:0]          r_ptr, w_ptr_nxt;
    logic [CHN_WIDTH:0]            w_first, w_next;
    logic                          w_hit, w_tmo;
    logic [DATA_WIDTH-1:0]         w_fdb_sel, w_ref_sel;
    logic                          r_valid, r_done, r_busy, r_ovr, r_tmo;
    logic [CHN_WIDTH-1:0]          r_chn;
    logic [DATA_WIDTH-1:0]         r_fdb, r_ref;
    logic [NUM_CHN*DATA_WIDTH-1:0] r_bank;
    logic [NUM_CHN-1:0]            r_upd;

    // Returns {found, index} of the lowest set mask bit at or above start.
    function automatic logic [CHN_WIDTH:0] find_set(input logic [NUM_CHN-1:0] mask, input int start);
        logic [CHN_WIDTH:0] res;
        res = '0;
        for (int i = NUM_CHN - 1; i >= 0; i--) begin
            if (mask[i] && (i >= start)) res = {1'b1, CHN_WIDTH'(i)};
        end
        return res;
    endfunction

    // The period length is sampled at the start of each count, so a new value only applies after a wrap.
    always_comb begin
        w_per_now = (period == '0) ? PERIOD_W'(1) : period;
        w_per_eff = (r_cnt == '0) ? w_per_now : r_per;
        w_tick    = enable && (r_cnt == w_per_eff - PERIOD_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_per <= '0;
        end else if (!enable) begin
            r_cnt <= '0;
        end else begin
            r_per <= w_per_eff;
            r_cnt <= w_tick ? '0 : r_cnt + PERIOD_W'(1);
        end
    end

    assign w_hit = (r_state == S_WAIT) && u_valid_i && (u_chn_i == r_ptr);

`ifdef PID_SCHED_TIMEOUT_EN
    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WCNT_W-1:0] r_wcnt;

    always_ff @(posedge clk) begin
        if (rst || (r_state != S_WAIT)) r_wcnt <= '0;
        else                            r_wcnt <= r_wcnt + WCNT_W'(1);
    end

    assign w_tmo = (r_state == S_WAIT) && !w_hit && (r_wcnt == WCNT_W'(TIMEOUT - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_first     = find_set(chn_mask, 0);
        w_next      = find_set(r_mask, int'(r_ptr) + 1);
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_ptr_nxt   = w_first[CHN_WIDTH-1:0];
                    w_state_nxt = w_first[CHN_WIDTH] ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: if (tready_i) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_hit || w_tmo) begin
                    w_ptr_nxt   = w_next[CHN_WIDTH] ? w_next[CHN_WIDTH-1:0] : r_ptr;
                    w_state_nxt = w_next[CHN_WIDTH] ? S_ISSUE : S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // The first request of a frame comes straight from the inputs being snapshotted this cycle.
        w_fdb_sel = (r_state == S_IDLE) ? fdb_i[w_ptr_nxt*DATA_WIDTH +: DATA_WIDTH] : r_snap_fdb[w_ptr_nxt];
        w_ref_sel = (r_state == S_IDLE) ? ref_i[w_ptr_nxt*DATA_WIDTH +: DATA_WIDTH] : r_snap_ref[w_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask  <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_chn   <= '0;
            r_fdb   <= '0;
            r_ref   <= '0;
            r_bank  <= '0;
            r_upd   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
            r_tmo   <= 1'b0;
            for (int i = 0; i < NUM_CHN; i++) begin
                r_snap_fdb[i] <= '0;
                r_snap_ref[i] <= '0;
            end
        end else begin
            if ((r_state == S_IDLE) && w_tick) begin
                r_mask <= chn_mask;
                for (int i = 0; i < NUM_CHN; i++) begin
                    r_snap_fdb[i] <= fdb_i[i*DATA_WIDTH +: DATA_WIDTH];
                    r_snap_ref[i] <= ref_i[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            r_ptr   <= w_ptr_nxt;
            r_valid <= (w_state_nxt == S_ISSUE);
            if (w_state_nxt == S_ISSUE) begin
                r_chn <= w_ptr_nxt;
                r_fdb <= w_fdb_sel;
                r_ref <= w_ref_sel;
            end
            r_upd <= '0;
            if (w_hit) begin
                r_bank[r_ptr*DATA_WIDTH +: DATA_WIDTH] <= u_data_i;
                r_upd <= NUM_CHN'(1) << r_ptr;
            end
            r_done <= (r_state == S_DONE);
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_tick && (r_state != S_IDLE)) r_ovr <= 1'b1;
            if (w_tmo) r_tmo <= 1'b1;
        end
    end

    assign data_valid_o = r_valid;
    assign data_chn_o   = r_chn;
    assign data_fdb_o   = r_fdb;
    assign data_ref_o   = r_ref;
    assign u_bank_o     = r_bank;
    assign u_update_o   = r_upd;
    assign frame_done_o = r_done;
    assign busy_o       = r_busy;
    assign overrun_o    = r_ovr;
    assign timeout_o    = r_tmo;

endmodule

// File: tb/tb_pid_frame_scheduler.sv
// Bench for pid_frame_scheduler: scenario table, hand-written corner sequences and randomized frames
// checked cycle by cycle against a transaction-level model of the frame schedule.
module tb_pid_frame_scheduler;
    localparam int DW = 16, NC = 4, CW = 2, PW = 16, TMO = 64;

    logic              clk = 1'b0;
    logic              rst, enable, tready_i, u_valid_i;
    logic [PW-1:0]     period;
    logic [NC-1:0]     chn_mask;
    logic [NC*DW-1:0]  fdb_i, ref_i;
    logic [CW-1:0]     u_chn_i;
    logic [DW-1:0]     u_data_i;
    logic              data_valid_o, frame_done_o, busy_o, overrun_o, timeout_o;
    logic [CW-1:0]     data_chn_o;
    logic [DW-1:0]     data_fdb_o, data_ref_o;
    logic [NC*DW-1:0]  u_bank_o;
    logic [NC-1:0]     u_update_o;

    pid_frame_scheduler #(.DATA_WIDTH(DW), .NUM_CHN(NC), .PERIOD_W(PW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .chn_mask(chn_mask),
        .fdb_i(fdb_i), .ref_i(ref_i), .data_valid_o(data_valid_o), .data_chn_o(data_chn_o),
        .data_fdb_o(data_fdb_o), .data_ref_o(data_ref_o), .tready_i(tready_i),
        .u_valid_i(u_valid_i), .u_chn_i(u_chn_i), .u_data_i(u_data_i), .u_bank_o(u_bank_o),
        .u_update_o(u_update_o), .frame_done_o(frame_done_o), .busy_o(busy_o),
        .overrun_o(overrun_o), .timeout_o(timeout_o));

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_chk = 0, n_fail = 0;

    // Reference model state: the channels still to serve this frame, in order.
    int          q_chn[$];
    bit          m_issuing, m_waiting, m_done_pend, m_done_now, m_ovr, m_tmo;
    int          m_wait_edges, ecnt;
    logic [3:0]  m_upd;
    logic [15:0] m_bank[NC], m_sfdb[NC], m_sref[NC];

    // Emulated PID core.
    int stall_cfg, lat_cfg, stall_left, c_ucnt, c_pend, drop_chn = -1, frames_seen;
    bit spur_en, rand_mask;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void advance();
        void'(q_chn.pop_front());
        m_waiting = 0;
        if (q_chn.size() != 0) m_issuing = 1;
        else                   m_done_pend = 1;
    endfunction

    function automatic void start_frame(input logic [3:0] mask, input logic [63:0] f, input logic [63:0] r);
        for (int i = 0; i < NC; i++) begin
            m_sfdb[i] = f[i*DW +: DW];
            m_sref[i] = r[i*DW +: DW];
            if (mask[i]) q_chn.push_back(i);
        end
        if (q_chn.size() != 0) m_issuing = 1;
        else                   m_done_pend = 1;
    endfunction

    task automatic do_reset();
        rst = 1; enable = 0; tready_i = 1; u_valid_i = 0; u_chn_i = 0; u_data_i = 0;
        chn_mask = 0; period = 1; fdb_i = 0; ref_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", data_valid_o, 0);
        chk("rst_chn", data_chn_o, 0);
        chk("rst_fdb", data_fdb_o, 0);
        chk("rst_ref", data_ref_o, 0);
        chk("rst_bank", u_bank_o, 0);
        chk("rst_upd", u_update_o, 0);
        chk("rst_done", frame_done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovr", overrun_o, 0);
        chk("rst_tmo", timeout_o, 0);
        rst = 0;
        q_chn.delete();
        m_issuing = 0; m_waiting = 0; m_done_pend = 0; m_done_now = 0; m_ovr = 0; m_tmo = 0;
        m_wait_edges = 0; ecnt = 0; m_upd = 0;
        for (int i = 0; i < NC; i++) begin
            m_bank[i] = 0; m_sfdb[i] = 0; m_sref[i] = 0;
        end
        c_ucnt = 0; c_pend = 0; frames_seen = 0; stall_left = stall_cfg;
    endtask

    // One clock: advance the model over the edge, play the core's side, then compare.
    task automatic cyc();
        bit          pre_en, pre_rdy, pre_uv, tick, accept, hit, busy_before;
        int          pre_p, pre_uc, pre_chn;
        logic [15:0] pre_ud;
        logic [3:0]  pre_mask;
        logic [63:0] pre_fdb, pre_ref, bank_pk;
        pre_en   = enable;
        pre_p    = (period == 0) ? 1 : int'(period);
        pre_rdy  = tready_i;
        pre_uv   = u_valid_i;
        pre_uc   = int'(u_chn_i);
        pre_ud   = u_data_i;
        pre_mask = chn_mask;
        pre_fdb  = fdb_i;
        pre_ref  = ref_i;
        pre_chn  = int'(data_chn_o);
        @(posedge clk);
        #1;
        tick        = pre_en && ((ecnt % pre_p) == pre_p - 1);
        ecnt        = pre_en ? ecnt + 1 : 0;
        busy_before = m_issuing || m_waiting || m_done_pend;
        m_upd       = 0;
        m_done_now  = m_done_pend;
        m_done_pend = 0;
        accept      = m_issuing && pre_rdy;
        hit         = m_waiting && pre_uv && (pre_uc == q_chn[0]);
        if (accept) begin
            m_issuing = 0; m_waiting = 1; m_wait_edges = 0;
        end else if (m_waiting) begin
            if (hit) begin
                m_bank[q_chn[0]] = pre_ud;
                m_upd[q_chn[0]]  = 1'b1;
                advance();
            end else begin
                m_wait_edges++;
`ifdef PID_SCHED_TIMEOUT_EN
                if (m_wait_edges == TMO) begin
                    m_tmo = 1;
                    advance();
                end
`endif
            end
        end
        if (tick) begin
            if (busy_before) m_ovr = 1;
            else             start_frame(pre_mask, pre_fdb, pre_ref);
        end

        u_valid_i = 0;
        u_chn_i   = CW'($urandom);
        u_data_i  = DW'($urandom);
        if (accept) begin
            c_pend = pre_chn; c_ucnt = lat_cfg; stall_left = stall_cfg;
        end
        if (c_ucnt > 0) begin
            c_ucnt--;
            if (c_ucnt == 0) begin
                if (c_pend != drop_chn) begin
                    u_valid_i = 1; u_chn_i = CW'(c_pend);
                end
            end else if (spur_en) begin
                u_valid_i = 1; u_chn_i = CW'((c_pend + 1) % NC);
            end
        end
        if (data_valid_o && stall_left > 0) begin
            tready_i = 0; stall_left--;
        end else begin
            tready_i = 1;
        end
        fdb_i = {$urandom, $urandom};
        ref_i = {$urandom, $urandom};
        if (rand_mask) chn_mask = NC'($urandom);
        if (frame_done_o) frames_seen++;

        for (int i = 0; i < NC; i++) bank_pk[i*DW +: DW] = m_bank[i];
        chk("valid", data_valid_o, m_issuing);
        if (m_issuing) begin
            chk("chn", data_chn_o, q_chn[0]);
            chk("fdb", data_fdb_o, m_sfdb[q_chn[0]]);
            chk("ref", data_ref_o, m_sref[q_chn[0]]);
        end
        chk("frame_done", frame_done_o, m_done_now);
        chk("busy", busy_o, m_issuing || m_waiting || m_done_pend);
        chk("u_update", u_update_o, m_upd);
        chk("bank", u_bank_o, bank_pk);
        chk("overrun", overrun_o, m_ovr);
        chk("timeout", timeout_o, m_tmo);
    endtask

    typedef struct {
        int         period;
        logic [3:0] mask;
        int         stall;
        int         lat;
        int         cycles;
        bit         rmask;
        int         exp_frames;
        bit         exp_ovr;
    } row_t;

    row_t rows[8];

    initial begin
        int first, vcnt;
        rows[0] = '{20, 4'hF, 0, 3, 100, 1'b0, 5, 1'b0};
        rows[1] = '{10, 4'hF, 0, 1, 100, 1'b0, 10, 1'b0};
        rows[2] = '{30, 4'hA, 5, 2, 90, 1'b0, 3, 1'b0};
        rows[3] = '{4, 4'hF, 0, 8, 48, 1'b0, 2, 1'b1};
        rows[4] = '{6, 4'h0, 0, 1, 36, 1'b0, 6, 1'b0};
        rows[5] = '{16, 4'h5, 1, 2, 64, 1'b0, 4, 1'b0};
        for (int r = 6; r < 8; r++)
            rows[r] = '{int'($urandom_range(3, 40)), 4'h0, int'($urandom_range(0, 3)),
                        int'($urandom_range(1, 6)), 300, 1'b1, -1, 1'b0};
        spur_en = 1; stall_cfg = 0; lat_cfg = 1; rand_mask = 0;

        for (int r = 0; r < 8; r++) begin
            stall_cfg = rows[r].stall; lat_cfg = rows[r].lat; rand_mask = rows[r].rmask;
            do_reset();
            period = PW'(rows[r].period); chn_mask = rows[r].mask; enable = 1;
            repeat (rows[r].cycles) cyc();
            enable = 0;
            repeat (150) cyc();
            if (rows[r].exp_frames >= 0) begin
                chk("row_frames", frames_seen, rows[r].exp_frames);
                chk("row_overrun", overrun_o, rows[r].exp_ovr);
            end
        end
        rand_mask = 0;

        // Empty mask: frame_done one edge after the tick edge, no request ever.
        stall_cfg = 0; lat_cfg = 1;
        do_reset();
        period = 3; chn_mask = 0; enable = 1;
        first = -1; vcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (frame_done_o && first < 0) first = k;
            vcnt += int'(data_valid_o);
        end
        chk("t5_done_cycle", first, 4);
        chk("t5_no_valid", vcnt, 0);

        // Back-pressured requests: each held for 5 stalled cycles plus the accepting one.
        stall_cfg = 5; lat_cfg = 2;
        do_reset();
        period = 30; chn_mask = 4'hA; enable = 1;
        vcnt = 0;
        repeat (55) begin
            cyc();
            vcnt += int'(data_valid_o);
        end
        chk("t3_valid_cycles", vcnt, 12);
        enable = 0;
        repeat (20) cyc();

`ifdef PID_SCHED_TIMEOUT_EN
        // Channel 2 never answers: skipped after the timeout, channel 3 still served.
        stall_cfg = 0; lat_cfg = 2; drop_chn = 2;
        do_reset();
        period = 300; chn_mask = 4'hF; enable = 1;
        repeat (400) cyc();
        chk("t6_timeout", timeout_o, 1);
        chk("t6_frames", frames_seen, 1);
        drop_chn = -1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
